uart_tx_fifo: RTL

Serial transmit path of the photo-frame UART link. It accepts single-cycle byte strobes from the control state machine, such as the 0xA5 acknowledge issued on every state change. Bytes are buffered in a small FIFO so that no strobe is lost while a frame is on the wire. Each byte is serialised onto the TX pin as 8N1, LSB first, at a fixed baud rate. This block is the transmit counterpart of the UART receiver that feeds the state machine.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo_if.sv | 34 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and link-level byte constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0]  UART_ACK       = 8'hA5;
  localparam logic [7:0]  UART_CMD       = 8'h5A;
  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-strobe input and status/serial outputs of the UART transmit path.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
);

  logic [7:0]                    i_data;
  logic                          i_valid;
  logic                          o_tx;
  logic                          o_busy;
  logic                          o_tx_done;
  logic                          o_overflow;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

  modport master (
    output i_data,
    output i_valid,
    input  o_tx,
    input  o_busy,
    input  o_tx_done,
    input  o_overflow,
    input  o_fifo_count
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_tx,
    output o_busy,
    output o_tx_done,
    output o_overflow,
    output o_fifo_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a separate occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_wr;
  logic             do_rd;

  assign o_full  = (count_q == FULL_COUNT);
  assign o_empty = (count_q == '0);
  assign do_rd   = i_rd_en && !o_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr   = i_wr_en && (!o_full || do_rd);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  assign o_dout  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte strobes go into a FIFO, an FSM serialises
// them LSB first at CLK_FREQ / BAUD cycles per bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           i_clk_sys,
  input  logic           i_rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int unsigned BAUD_DIV = baud_divisor(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned COUNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [CNT_W-1:0] baud_cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             tx_d;
  logic             tx_done_q;
  logic             tx_done_d;
  logic             overflow_q;
  logic             overflow_d;

  logic               pop;
  logic               baud_last;
  logic [7:0]         fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [COUNT_W-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.i_valid),
    .i_rd_en   (pop),
    .i_din     (bus.i_data),
    .o_dout    (fifo_dout),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // The line level is derived from the current state and registered, so o_tx
  // trails the state by one cycle and every bit on the wire lasts BAUD_DIV cycles.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    tx_d       = 1'b1;
    tx_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          tx_done_d  = 1'b1;
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop       = 1'b1;
            shift_d   = fifo_dout;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign overflow_d = bus.i_valid && fifo_full && !pop;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o_tx         = tx_q;
  assign bus.o_tx_done    = tx_done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_fifo_count = fifo_count;
  // tx_done_q covers the final stop-bit cycle still on the wire after the FSM idles.
  assign bus.o_busy       = (state_q != IDLE) || !fifo_empty || tx_done_q;

endmodule
